// File: rtl/ff_vec_driver.sv
// Stimulus/check stage for the FF dual-edge block: drives {a,b,c}, samples e at a fixed latency.
// Define FF_VEC_DRV_FIFO_EN to place a 4-entry {in_vec,in_exp} FIFO ahead of the FSM.
module ff_vec_driver #(
  parameter int HOLD  = 3,
  parameter int LAT   = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_vec,
  input  logic             in_exp,
  input  logic             clr,
  output logic             a,
  output logic             b,
  output logic             c,
  input  logic             e,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic {IDLE, DRIVE} state_e;

  state_e           state_q, state_d;
  logic [3:0]       ph_q, ph_d;
  logic [2:0]       abc_q, abc_d;
  logic             exp_q, exp_d;
  logic             done_q, done_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic             fsm_take;
  logic             accept;
  logic             sample;
  logic [2:0]       take_vec;
  logic             take_exp;

  assign fsm_take = (state_q == IDLE) || (ph_q == 4'(HOLD - 1));
  assign sample   = (state_q == DRIVE) && (ph_q == 4'(LAT - 1));

`ifdef FF_VEC_DRV_FIFO_EN
  logic [3:0] mem_q [4];
  logic [1:0] wr_q, rd_q;
  logic [2:0] lvl_q;
  logic       fifo_empty, fifo_full, push, push_mem, pop_mem, src_valid;

  assign fifo_empty = (lvl_q == 3'd0);
  assign fifo_full  = (lvl_q == 3'd4);
  // A full FIFO still takes a word when the FSM pops on the same edge.
  assign in_ready   = rst_n && (!fifo_full || fsm_take);
  assign push       = in_valid && in_ready;
  assign src_valid  = !fifo_empty || in_valid;
  assign accept     = rst_n && fsm_take && src_valid;
  assign take_vec   = fifo_empty ? in_vec : mem_q[rd_q][3:1];
  assign take_exp   = fifo_empty ? in_exp : mem_q[rd_q][0];
  assign pop_mem    = accept && !fifo_empty;
  assign push_mem   = push && !(accept && fifo_empty);

  always_ff @(posedge clk) begin
    if (push_mem) mem_q[wr_q] <= {in_vec, in_exp};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (push_mem) wr_q <= wr_q + 2'd1;
      if (pop_mem)  rd_q <= rd_q + 2'd1;
      lvl_q <= lvl_q + 3'(push_mem) - 3'(pop_mem);
    end
  end
`else
  assign in_ready = rst_n && fsm_take;
  assign accept   = in_valid && in_ready;
  assign take_vec = in_vec;
  assign take_exp = in_exp;
`endif

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    abc_d     = abc_q;
    exp_d     = exp_q;
    done_d    = 1'b0;
    mis_d     = 1'b0;
    vec_cnt_d = vec_cnt_q;
    err_cnt_d = err_cnt_q;

    if (sample) begin
      done_d = 1'b1;
      mis_d  = e ^ exp_q;
      if (vec_cnt_q != {CNT_W{1'b1}}) vec_cnt_d = vec_cnt_q + 1'b1;
      if (mis_d && (err_cnt_q != {CNT_W{1'b1}})) err_cnt_d = err_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          abc_d   = take_vec;
          exp_d   = take_exp;
          ph_d    = 4'd0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        ph_d = ph_q + 4'd1;
        if (ph_q == 4'(HOLD - 1)) begin
          ph_d = 4'd0;
          if (accept) begin
            abc_d = take_vec;
            exp_d = take_exp;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (clr) begin
      vec_cnt_d = '0;
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ph_q      <= '0;
      abc_q     <= '0;
      exp_q     <= 1'b0;
      done_q    <= 1'b0;
      mis_q     <= 1'b0;
      vec_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      abc_q     <= abc_d;
      exp_q     <= exp_d;
      done_q    <= done_d;
      mis_q     <= mis_d;
      vec_cnt_q <= vec_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign {a, b, c} = abc_q;
  assign busy      = (state_q == DRIVE);
  assign done      = done_q;
  assign mismatch  = mis_q;
  assign vec_cnt   = vec_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ff_vec_driver.sv
// Bench for ff_vec_driver: two instances (CNT_W=8 and CNT_W=2) share stimulus, each feeding a behavioural FF.
module tb_ff_vec_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_vec = 3'b000;
  logic       in_exp = 1'b0;
  logic       clr = 1'b0;

  logic       in_ready1, a1, b1, c1, e1, d1, busy1, done1, mis1;
  logic [7:0] vc1, ec1;
  logic       in_ready2, a2, b2, c2, e2, d2, busy2, done2, mis2;
  logic [1:0] vc2, ec2;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int mVec = 0, mErr = 0, mVec2 = 0, mErr2 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ff_vec_driver #(.HOLD(3), .LAT(2), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_vec(in_vec), .in_exp(in_exp), .clr(clr),
    .a(a1), .b(b1), .c(c1), .e(e1),
    .busy(busy1), .done(done1), .mismatch(mis1), .vec_cnt(vc1), .err_cnt(ec1)
  );

  ff_vec_driver #(.HOLD(3), .LAT(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_vec(in_vec), .in_exp(in_exp), .clr(clr),
    .a(a2), .b(b2), .c(c2), .e(e2),
    .busy(busy2), .done(done2), .mismatch(mis2), .vec_cnt(vc2), .err_cnt(ec2)
  );

  // Behavioural FF blocks: d = a&b on the falling edge, e = d|c on the next rising edge.
  always @(negedge clk) d1 <= a1 & b1;
  always @(posedge clk) e1 <= d1 | c1;
  always @(negedge clk) d2 <= a2 & b2;
  always @(posedge clk) e2 <= d2 | c2;

  function automatic int satInc(input int n, input int maxv);
    return (n < maxv) ? n + 1 : maxv;
  endfunction

  function automatic logic refMismatch(input logic [2:0] v, input logic x);
    return ((v[2] & v[1]) | v[0]) ^ x;
  endfunction

  task automatic noteSample(input logic m);
    mVec  = satInc(mVec, 255);
    mVec2 = satInc(mVec2, 3);
    if (m) begin
      mErr  = satInc(mErr, 255);
      mErr2 = satInc(mErr2, 3);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    mVec = 0; mErr = 0; mVec2 = 0; mErr2 = 0;
    total++; if ({a1, b1, c1} !== 3'b000) begin bad++; $display("[TB] FAIL rst_abc: got %b want 000", {a1, b1, c1}); end
    total++; if (vc1 !== 8'd0 || ec1 !== 8'd0) begin bad++; $display("[TB] FAIL rst_cnt: got %0d/%0d want 0/0", vc1, ec1); end
    total++; if (done1 !== 1'b0 || mis1 !== 1'b0 || busy1 !== 1'b0) begin bad++; $display("[TB] FAIL rst_flags: got done=%b mis=%b busy=%b want 0", done1, mis1, busy1); end
    total++; if (in_ready1 !== 1'b0) begin bad++; $display("[TB] FAIL rst_ready_low: got %b want 0", in_ready1); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready1 !== 1'b1) begin bad++; $display("[TB] FAIL rst_ready_release: got %b want 1", in_ready1); end
  endtask

  task automatic test_single_vector(input logic [2:0] v, input logic x);
    logic m;
    int k;
    m = refMismatch(v, x);
    in_vec = v; in_exp = x; in_valid = 1'b1;
    k = 0;
    while (in_ready1 !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    total++; if (in_ready1 !== 1'b1) begin bad++; $display("[TB] FAIL ready_timeout: got %b want 1", in_ready1); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if ({a1, b1, c1} !== v) begin bad++; $display("[TB] FAIL drive_abc: got %b want %b", {a1, b1, c1}, v); end
    total++; if (busy1 !== 1'b1) begin bad++; $display("[TB] FAIL drive_busy: got %b want 1", busy1); end
    @(posedge clk); #1;
    total++; if (done1 !== 1'b0) begin bad++; $display("[TB] FAIL early_done: got %b want 0", done1); end
    @(posedge clk); #1;
    noteSample(m);
    total++; if (done1 !== 1'b1) begin bad++; $display("[TB] FAIL sample_done: got %b want 1", done1); end
    total++; if (mis1 !== m) begin bad++; $display("[TB] FAIL sample_mismatch: got %b want %b (vec %b exp %b)", mis1, m, v, x); end
    total++; if (vc1 !== 8'(mVec) || ec1 !== 8'(mErr)) begin bad++; $display("[TB] FAIL cnt8: got %0d/%0d want %0d/%0d", vc1, ec1, mVec, mErr); end
    total++; if (vc2 !== 2'(mVec2) || ec2 !== 2'(mErr2)) begin bad++; $display("[TB] FAIL cnt2: got %0d/%0d want %0d/%0d", vc2, ec2, mVec2, mErr2); end
    @(posedge clk); #1;
    total++; if (done1 !== 1'b0 || busy1 !== 1'b0) begin bad++; $display("[TB] FAIL after_idle: got done=%b busy=%b want 0/0", done1, busy1); end
    total++; if ({a1, b1, c1} !== v) begin bad++; $display("[TB] FAIL idle_hold_abc: got %b want %b", {a1, b1, c1}, v); end
  endtask

  task automatic test_pass();
    test_single_vector(3'b110, 1'b1);
    total++; if (vc1 !== 8'd1 || ec1 !== 8'd0) begin bad++; $display("[TB] FAIL pass_cnt: got %0d/%0d want 1/0", vc1, ec1); end
  endtask

  task automatic test_mismatch();
    test_single_vector(3'b000, 1'b1);
    total++; if (ec1 !== 8'd1) begin bad++; $display("[TB] FAIL mismatch_err: got %0d want 1", ec1); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      test_single_vector(3'($urandom_range(7)), 1'($urandom_range(1)));
      repeat ($urandom_range(2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] v [4];
    logic       x [4];
    logic       mq [$];
    int         dq [$];
    int         acc [$];
    int         idx, nd, dlt;
    logic       rdy, m;
    for (int i = 0; i < 4; i++) begin
      v[i] = 3'($urandom_range(7));
      x[i] = 1'($urandom_range(1));
    end
    idx = 0; nd = 0;
    in_vec = v[0]; in_exp = x[0]; in_valid = 1'b1;
    for (int k = 0; k < 40 && nd < 4; k++) begin
      rdy = in_ready1;
      if (acc.size() > 0) begin
        dlt = cyc - acc[acc.size() - 1];
        if (dlt <= 2) begin
          total++; if (rdy !== (dlt == 2)) begin bad++; $display("[TB] FAIL b2b_ready_ph%0d: got %b want %b", dlt, rdy, (dlt == 2)); end
        end
      end
      @(posedge clk); #1;
      if (rdy && in_valid) begin
        acc.push_back(cyc);
        dq.push_back(cyc);
        mq.push_back(refMismatch(v[idx], x[idx]));
        idx++;
        if (idx < 4) begin in_vec = v[idx]; in_exp = x[idx]; end
        else in_valid = 1'b0;
      end
      if (done1 === 1'b1) begin
        nd++;
        if (mq.size() == 0) begin
          total++; bad++; $display("[TB] FAIL b2b_spurious_done: got 1 want 0");
        end else begin
          m = mq.pop_front();
          dlt = dq.pop_front();
          noteSample(m);
          total++; if (cyc !== dlt + 2) begin bad++; $display("[TB] FAIL b2b_done_time: got %0d want %0d", cyc, dlt + 2); end
          total++; if (mis1 !== m) begin bad++; $display("[TB] FAIL b2b_mismatch: got %b want %b", mis1, m); end
        end
      end
    end
    in_valid = 1'b0;
    total++; if (acc.size() !== 4) begin bad++; $display("[TB] FAIL b2b_accepts: got %0d want 4", acc.size()); end
    for (int i = 1; i < acc.size(); i++) begin
      total++; if (acc[i] - acc[i-1] !== 3) begin bad++; $display("[TB] FAIL b2b_spacing: got %0d want 3", acc[i] - acc[i-1]); end
    end
    total++; if (nd !== 4) begin bad++; $display("[TB] FAIL b2b_done_count: got %0d want 4", nd); end
    total++; if (vc1 !== 8'(mVec) || ec1 !== 8'(mErr)) begin bad++; $display("[TB] FAIL b2b_cnt: got %0d/%0d want %0d/%0d", vc1, ec1, mVec, mErr); end
    @(posedge clk); #1;
    total++; if (busy1 !== 1'b0) begin bad++; $display("[TB] FAIL b2b_idle: got %b want 0", busy1); end
  endtask

  task automatic test_saturation_clear();
    test_reset();
    for (int i = 0; i < 5; i++) test_single_vector(3'b000, 1'b1);
    total++; if (ec2 !== 2'd3 || vc2 !== 2'd3) begin bad++; $display("[TB] FAIL sat_cnt2: got %0d/%0d want 3/3", vc2, ec2); end
    total++; if (ec1 !== 8'd5) begin bad++; $display("[TB] FAIL sat_cnt8: got %0d want 5", ec1); end
    in_vec = 3'b111; in_exp = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    mVec = 0; mErr = 0; mVec2 = 0; mErr2 = 0;
    total++; if (done1 !== 1'b1 || mis1 !== 1'b0 || busy1 !== 1'b1) begin bad++; $display("[TB] FAIL clr_outputs: got done=%b mis=%b busy=%b want 1/0/1", done1, mis1, busy1); end
    total++; if (vc1 !== 8'd0 || ec1 !== 8'd0 || vc2 !== 2'd0 || ec2 !== 2'd0) begin bad++; $display("[TB] FAIL clr_cnt: got %0d/%0d/%0d/%0d want 0", vc1, ec1, vc2, ec2); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_drive();
    in_vec = 3'b110; in_exp = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    mVec = 0; mErr = 0; mVec2 = 0; mErr2 = 0;
    total++; if (done1 !== 1'b0 || busy1 !== 1'b0) begin bad++; $display("[TB] FAIL midrst_flags: got done=%b busy=%b want 0/0", done1, busy1); end
    total++; if ({a1, b1, c1} !== 3'b000 || in_ready1 !== 1'b0) begin bad++; $display("[TB] FAIL midrst_abc_ready: got %b/%b want 000/0", {a1, b1, c1}, in_ready1); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (done1 !== 1'b0 || vc1 !== 8'd0 || ec1 !== 8'd0) begin bad++; $display("[TB] FAIL midrst_discard: got done=%b cnt=%0d/%0d want 0", done1, vc1, ec1); end
    test_pass();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_pass();
    test_mismatch();
    test_random();
    test_back_to_back();
    test_saturation_clear();
    test_reset_mid_drive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
